pattern_game_ctrl: RTL



---
 rtl/pattern_game_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_game_ctrl.sv
// Pattern-matching game engine: countdown timer, entry register, level-weighted scoring, per-user high scores.
// Optional build macro MISMATCH_PENALTY_EN: a full-length wrong entry costs one point and clears the entry.

module pattern_game_ctrl #(
    parameter int unsigned SYM_W         = 3,
    parameter int unsigned NUM_SYM       = 7,
    parameter int unsigned TIMER_DIGITS  = 2,
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned NUM_USERS     = 4,
    parameter int unsigned SCORE_W       = 4,
    localparam int unsigned PW = SYM_W * NUM_SYM,
    localparam int unsigned UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
    localparam int unsigned TW = 4 * TIMER_DIGITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [UW-1:0]      i_user_id,
    input  logic [1:0]         i_level,
    input  logic [PW-1:0]      i_target,
    input  logic               i_target_valid,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [SYM_W-1:0]   i_sym_in,
    output logic [PW-1:0]      o_entry,
    output logic [TW-1:0]      o_timer_bcd,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_score_max,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_match_pulse,
    output logic               o_new_target_req
);

    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SUM_W = ((SCORE_W > 3) ? SCORE_W : 3) + 1;
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SCORE_W-1:0] SCORE_SAT  = '1;
    localparam logic [TW-1:0]      TIMER_FULL = {TIMER_DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TGT,
        S_PLAY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic [UW-1:0]        r_user,    w_user_nxt;
    logic [1:0]           r_level,   w_level_nxt;
    logic [PW-1:0]        r_entry,   w_entry_nxt;
    logic [TW-1:0]        r_timer,   w_timer_nxt;
    logic [PRE_W-1:0]     r_pre,     w_pre_nxt;
    logic [SCORE_W-1:0]   r_score,   w_score_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic                 r_match,   w_match_nxt;
    logic                 r_ntr,     w_ntr_nxt;
    logic [SCORE_W-1:0]   r_table [NUM_USERS];

    logic [TW-1:0]        w_dec;
    logic                 w_borrow;
    logic                 w_run;
    logic [SUM_W-1:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_inc;

`ifdef MISMATCH_PENALTY_EN
    localparam int unsigned CNT_W = $clog2(NUM_SYM + 1);
    logic [CNT_W-1:0]     r_lcnt, w_lcnt_nxt;
`endif

    // BCD countdown by one, borrowing 0 -> 9 into the next digit
    always_comb begin
        w_dec    = r_timer;
        w_borrow = 1'b1;
        for (int unsigned d = 0; d < TIMER_DIGITS; d++) begin
            if (w_borrow) begin
                if (r_timer[4*d +: 4] == 4'd0) begin
                    w_dec[4*d +: 4] = 4'h9;
                end else begin
                    w_dec[4*d +: 4] = r_timer[4*d +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    assign w_run       = (r_state == S_WAIT_TGT) || (r_state == S_PLAY) || (r_state == S_CHECK);
    assign w_sum       = SUM_W'(r_score) + SUM_W'(r_level) + SUM_W'(1);
    assign w_score_inc = (w_sum > SUM_W'(SCORE_SAT)) ? SCORE_SAT : SCORE_W'(w_sum);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_user_nxt    = r_user;
        w_level_nxt   = r_level;
        w_entry_nxt   = r_entry;
        w_timer_nxt   = r_timer;
        w_pre_nxt     = r_pre;
        w_score_nxt   = r_score;
        w_timeout_nxt = 1'b0;
        w_match_nxt   = 1'b0;
        w_ntr_nxt     = 1'b0;
`ifdef MISMATCH_PENALTY_EN
        w_lcnt_nxt    = r_lcnt;
`endif

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_user_nxt  = i_user_id;
                    w_level_nxt = i_level;
                    w_score_nxt = '0;
                    w_entry_nxt = '0;
                    w_timer_nxt = TIMER_FULL;
                    w_pre_nxt   = '0;
                    w_ntr_nxt   = 1'b1;
                    w_state_nxt = S_WAIT_TGT;
`ifdef MISMATCH_PENALTY_EN
                    w_lcnt_nxt  = '0;
`endif
                end
            end
            S_WAIT_TGT: begin
                if (i_target_valid) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (i_load) begin
                    w_entry_nxt = {r_entry[PW-SYM_W-1:0], i_sym_in};
                    w_state_nxt = S_CHECK;
`ifdef MISMATCH_PENALTY_EN
                    if (r_lcnt != CNT_W'(NUM_SYM)) begin
                        w_lcnt_nxt = r_lcnt + CNT_W'(1);
                    end
`endif
                end else if (i_shift) begin
                    w_entry_nxt = {r_entry[PW-SYM_W-1:0], r_entry[PW-1:PW-SYM_W]};
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_entry == i_target) begin
                    w_score_nxt = w_score_inc;
                    w_match_nxt = 1'b1;
                    w_ntr_nxt   = 1'b1;
                    w_entry_nxt = '0;
                    w_state_nxt = S_WAIT_TGT;
`ifdef MISMATCH_PENALTY_EN
                    w_lcnt_nxt  = '0;
`endif
                end else begin
                    w_state_nxt = S_PLAY;
`ifdef MISMATCH_PENALTY_EN
                    if (r_lcnt == CNT_W'(NUM_SYM)) begin
                        w_score_nxt = (r_score != '0) ? (r_score - SCORE_W'(1)) : '0;
                        w_entry_nxt = '0;
                        w_lcnt_nxt  = '0;
                    end
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Timer overrides the game flow: expiry ends the game after any match is scored
        if (w_run) begin
            if (r_pre == PRE_LAST) begin
                w_pre_nxt   = '0;
                w_timer_nxt = w_dec;
                if (w_dec == '0) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end else begin
                w_pre_nxt = r_pre + PRE_W'(1);
            end
        end

        w_busy_nxt = (w_state_nxt == S_WAIT_TGT) || (w_state_nxt == S_PLAY) ||
                     (w_state_nxt == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_user    <= '0;
            r_level   <= '0;
            r_entry   <= '0;
            r_timer   <= '0;
            r_pre     <= '0;
            r_score   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_match   <= 1'b0;
            r_ntr     <= 1'b0;
            for (int unsigned u = 0; u < NUM_USERS; u++) begin
                r_table[u] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_user    <= w_user_nxt;
            r_level   <= w_level_nxt;
            r_entry   <= w_entry_nxt;
            r_timer   <= w_timer_nxt;
            r_pre     <= w_pre_nxt;
            r_score   <= w_score_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_match   <= w_match_nxt;
            r_ntr     <= w_ntr_nxt;
            // Score is frozen in DONE, so writing on every DONE cycle equals writing on entry
            if ((r_state == S_DONE) && (r_score > r_table[r_user])) begin
                r_table[r_user] <= r_score;
            end
        end
    end

`ifdef MISMATCH_PENALTY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcnt <= '0;
        end else begin
            r_lcnt <= w_lcnt_nxt;
        end
    end
`endif

    assign o_entry          = r_entry;
    assign o_timer_bcd      = r_timer;
    assign o_score          = r_score;
    assign o_busy           = r_busy;
    assign o_timeout        = r_timeout;
    assign o_match_pulse    = r_match;
    assign o_new_target_req = r_ntr;
    // High-score lookup follows the live user_id only while idle
    assign o_score_max      = (r_state == S_IDLE) ? r_table[i_user_id] : r_table[r_user];

endmodule
